// File: rtl/counter_capture.sv
// counter_capture: FWFT capture queue for counter samples with drop flag and saturating wrap counter.
module counter_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     sample,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [7:0]               wrap_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [WIDTH-1:0] prev;
  logic prev_ok, pop, push, drop, wrap;
  assign rd_valid = count != '0;
  assign rd_data = mem[head];
  assign pop = rd_valid && rd_ready;
  assign push = sample && (count != FULL || pop);
  assign drop = sample && !push;
  assign wrap = prev_ok && prev == '1 && data_in == '0;
  always_ff @(posedge clk)
    if (push) mem[tail] <= data_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      overflow <= 1'b0;
      wrap_cnt <= '0;
      prev_ok <= 1'b0;
      prev <= '0;
    end else begin
      prev <= data_in;
      prev_ok <= 1'b1;
      if (pop) head <= head + AW'(1);
      if (push) tail <= tail + AW'(1);
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // a drop in the same cycle as a clear keeps the flag set
      if (drop) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (wrap && wrap_cnt != 8'hFF) wrap_cnt <= wrap_cnt + 8'd1;
    end
  end
endmodule
